// File: rtl/u_xmit_arb.sv
// u_xmit_arb - four-port round-robin scheduler in front of the UART transmitter.
//
// Takes requests from four clients, picks one with a rotating pointer, hands
// its byte to the transmitter (xmitH / xmit_dataH), and follows the
// transmitter's idle level (xmit_doneH) through one frame before it serves
// the next client.
//
// Ports
//   sys_clk     in   clock, rising edge
//   sys_rst_l   in   asynchronous active-low reset
//   req_h       in   [3:0]  per-requester request level
//   req_data_h  in   [31:0] requester n byte on [8n+7:8n]
//   grant_h     out  [3:0]  one-cycle pulse, winner's byte accepted
//   done_h      out  [3:0]  one-cycle pulse, winner's frame finished
//   timeout_h   out  one-cycle pulse, frame aborted by the watchdog
//   busy_h      out  high while not idle
//   xmitH       out  start strobe to the transmitter
//   xmit_dataH  out  [7:0]  byte to the transmitter
//   xmit_doneH  in   transmitter idle level
//
// Build option: define ARB_TIMEOUT_EN to add the frame watchdog
// (TIMEOUT_CYCLES, 2..65535). Without it timeout_h is held at 0.
//
// state        | meaning
// ARB_IDLE     | waiting for an idle transmitter and a request
// ARB_LOAD     | one cycle: strobe the transmitter, pulse the grant
// ARB_WAITBUSY | waiting for the transmitter to go busy
// ARB_WAITDONE | waiting for the transmitter to return to idle

module u_xmit_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        sys_clk,
  input  logic        sys_rst_l,
  input  logic [3:0]  req_h,
  input  logic [31:0] req_data_h,
  output logic [3:0]  grant_h,
  output logic [3:0]  done_h,
  output logic        timeout_h,
  output logic        busy_h,
  output logic        xmitH,
  output logic [7:0]  xmit_dataH,
  input  logic        xmit_doneH
);

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_LOAD     = 2'd1,
    ARB_WAITBUSY = 2'd2,
    ARB_WAITDONE = 2'd3
  } arb_state_t;

  arb_state_t r_state;
  arb_state_t w_next;
  logic [1:0] r_sel;
  logic [1:0] r_rr_ptr;
  logic [7:0] r_data;
  logic       w_found;
  logic [1:0] w_win;
  logic       w_start;
  logic       w_frame_end;
  logic       w_wd_hit;

  // Search rr_ptr, rr_ptr+1, ... modulo 4. The loop runs from the farthest
  // offset down so the nearest asserted request is the last one written.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_rr_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req_h[r_rr_ptr + 2'(i)]) begin
        w_found = 1'b1;
        w_win   = r_rr_ptr + 2'(i);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [15:0] r_wd_cnt;

  // Cleared while loading so the count starts at 0 on ARB_WAITBUSY entry.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      r_wd_cnt <= 16'd0;
    end else if (r_state == ARB_LOAD) begin
      r_wd_cnt <= 16'd0;
    end else if (r_state == ARB_WAITBUSY || r_state == ARB_WAITDONE) begin
      r_wd_cnt <= r_wd_cnt + 16'd1;
    end
  end

  assign w_wd_hit = (r_wd_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  // No watchdog: the compare folds to 0 for every legal TIMEOUT_CYCLES.
  assign w_wd_hit = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    w_next    = r_state;
    grant_h   = 4'b0000;
    done_h    = 4'b0000;
    timeout_h = 1'b0;
    xmitH     = 1'b0;
    busy_h    = (r_state != ARB_IDLE);
    case (r_state)
      ARB_IDLE: begin
        if (xmit_doneH && w_found) w_next = ARB_LOAD;
      end
      ARB_LOAD: begin
        xmitH          = 1'b1;
        grant_h[r_sel] = 1'b1;
        w_next         = ARB_WAITBUSY;
      end
      ARB_WAITBUSY: begin
        if (w_wd_hit) begin
          timeout_h = 1'b1;
          w_next    = ARB_IDLE;
        end else if (!xmit_doneH) begin
          w_next = ARB_WAITDONE;
        end
      end
      ARB_WAITDONE: begin
        // A completion on the watchdog's last cycle still counts as done.
        if (xmit_doneH) begin
          done_h[r_sel] = 1'b1;
          w_next        = ARB_IDLE;
        end else if (w_wd_hit) begin
          timeout_h = 1'b1;
          w_next    = ARB_IDLE;
        end
      end
      default: w_next = ARB_IDLE;
    endcase
  end

  assign w_start     = (r_state == ARB_IDLE) && (w_next == ARB_LOAD);
  assign w_frame_end = (done_h != 4'b0000) || timeout_h;
  assign xmit_dataH  = r_data;

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      r_state  <= ARB_IDLE;
      r_sel    <= 2'd0;
      r_rr_ptr <= 2'd0;
      r_data   <= 8'h00;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_sel  <= w_win;
        r_data <= req_data_h[{w_win, 3'b000} +: 8];
      end
      // The served requester drops to lowest priority for the next pick.
      if (w_frame_end) r_rr_ptr <= r_sel + 2'd1;
    end
  end

endmodule
